lfsr_seg_display: RTL and testbench
===================================

# lfsr_seg_display

- Parametrised Fibonacci LFSR sequence generator with a built-in seven-segment readout, for the Vaman (QuickLogic EOS S3) board.
- Steps the LFSR from a programmable prescaler tick or a manual step pulse, and shows the low nibble of the state as a hex digit on active-low segment outputs `a`..`g`.
- Reports sequence wrap-around and the measured period of the last complete cycle.
- Replaces the fixed 4-bit, fixed-pattern register/display logic with arbitrary width, taps, seed and step rate.

## Interface
Parameters:
- `WIDTH`, 4: LFSR width, legal 4..32.
- `TAPS`, 4'b0011: feedback mask; bit i set means `state[i]` enters the feedback XOR.
- `SEED`, 4'b0001: reset state, also the lockup-recovery state.
- `TICK_DIV`, 20000000: clock cycles per free-run step (1 s at 20 MHz); legal values are 1 and above.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock (`Sys_Clk0`).
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  free-run enable.
- `step`  in  1  single-step request; honoured only when `en`=0.
- `load`  in  1  load `seed_in` into the state.
- `seed_in`  in  WIDTH  value to load.
- `state`  out  WIDTH  current LFSR state.
- `tick`  out  1  one-cycle pulse after each step.
- `wrap`  out  1  one-cycle pulse when a step returns the state to the reference seed.
- `period`  out  WIDTH  step count of the last complete cycle.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`  out  1 each  segment drives, active-low (0 = lit).

## Operation
- **Step rule.**
  - Feedback: `fb` = XOR of `state[i]` over all bits where `TAPS[i]`=1.
  - Next state: {`fb`, `state[WIDTH-1:1]`} (shift right, new MSB).
- **Step sources.**
  - `en`=1: the prescaler counts 0..`TICK_DIV`-1. When it reaches `TICK_DIV`-1, a step occurs and the counter returns to 0.
  - `en`=0: the prescaler is cleared. Each cycle with `step`=1 performs one step, so a level-held `step` steps every cycle. `step` is ignored while `en`=1.
- **Load.**
  - On `load`: `state` <= `seed_in`, reference seed <= `seed_in`, prescaler <= 0, step counter <= 0.
  - No `tick` or `wrap` is generated that cycle.
  - `load` has priority over any step in the same cycle.
- **Wrap and period.**
  - An internal step counter (WIDTH bits, saturating at all-ones) increments on each step.
  - If the next state equals the reference seed, the step also asserts `wrap`, sets `period` <= counter+1 (saturating) and clears the counter.
- **Display.**
  - Segment outputs are registered decodes of `state[3:0]` as a hex digit 0-F, in {a,b,c,d,e,f,g} order.
  - Examples: 0=0000001, 1=1001111, 8=0000000, 9=0000100, A=0001000, F=0111000.
  - Segments are updated on the same edge as `state`, so they always match it.
- **Reset values.**
  - `state`=`SEED`, reference seed=`SEED`, segments=decode(`SEED`[3:0]).
  - `tick`=0, `wrap`=0, `period`=0, prescaler=0, step counter=0.
- **Reset mid-operation.** Asynchronous assertion forces the reset values immediately. Operation resumes on the first clock edge after release.

## Timing
- A step takes effect at the edge where its condition is sampled. `state`, segments, `tick` and `wrap` all update at that edge, giving zero added latency.
- `tick` and `wrap` are high for exactly one cycle per step.
- With `en` held at 1, the first step occurs `TICK_DIV` cycles after reset release or after `load`. Steps then follow every `TICK_DIV` cycles.
- `TICK_DIV`=1: a step every cycle while `en`=1.
- Deasserting `en` mid-count discards the partial count.

## Configuration
- Macro: `LFSR_SEG_LOCKUP_RECOVER_EN`.
- Defined: a step from the all-zero state yields `SEED` instead of all-zero. A `load` of zero is still accepted, and recovery happens on the next step.
- Undefined: the all-zero state is a fixed point. If the reference seed is zero, `wrap` pulses on every step and `period`=1.

## Test plan
- Reset with defaults (WIDTH=4, TAPS=0011, SEED=0001, TICK_DIV=4), `en`=1 -> `state`=0001 and segments=1001111 during reset. The first `tick` comes 4 cycles after release with `state`=1000 and segments=0000000.
- `en`=0, 15 single `step` pulses from 0001 -> sequence 1000,0100,0010,1001,1100,…,0011,0001. `wrap` is high only on step 15, then `period`=15.
- `load`=1 with `seed_in`=1010 in the same cycle as a prescaler step -> `state`=1010 and no `tick`. 15 further steps give `wrap` and `period`=15.
- `step` asserted while `en`=1 -> ignored; steps occur only every `TICK_DIV` cycles.
- Macro defined, load 0000 then one step -> `state`=0001. Macro undefined -> `state` stays 0000, with `wrap` pulsing each step and `period`=1.
- Assert `rst_n` low mid-count (prescaler=2, `state`=0110) -> immediate `state`=0001, `period`=0. The first `tick` follows 4 cycles after release.

Source files
------------

// File: rtl/lfsr_seg_display.sv
// lfsr_seg_display: Fibonacci LFSR stepped by prescaler or manual pulse, with wrap/period tracking and hex seven-segment readout; LFSR_SEG_LOCKUP_RECOVER_EN turns the all-zero state into a step back to SEED.
module lfsr_seg_display #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(4'b0011),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(4'b0001),
  parameter int TICK_DIV = 20000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             tick,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             f,
  output logic             g
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [PW-1:0]    pres;
  logic [WIDTH-1:0] ref_seed, cnt, cnt_inc, nxt, state_d;
  logic [6:0]       seg;
  logic             fb, fire, hit;
  assign fb = ^(state & TAPS);
`ifdef LFSR_SEG_LOCKUP_RECOVER_EN
  assign nxt = (state == '0) ? SEED : {fb, state[WIDTH-1:1]};
`else
  assign nxt = {fb, state[WIDTH-1:1]};
`endif
  assign fire    = !load && (en ? pres == LAST : step);
  assign hit     = nxt == ref_seed;
  assign cnt_inc = &cnt ? cnt : cnt + WIDTH'(1);
  assign state_d = load ? seed_in : fire ? nxt : state;
  assign {a, b, c, d, e, f, g} = seg;
  // segments decode the incoming state so they change on the same edge as state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres     <= '0;
      state    <= SEED;
      ref_seed <= SEED;
      cnt      <= '0;
      period   <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      seg      <= HEX[SEED[3:0]];
    end else begin
      pres     <= (load || !en || pres == LAST) ? '0 : pres + PW'(1);
      state    <= state_d;
      seg      <= HEX[state_d[3:0]];
      ref_seed <= load ? seed_in : ref_seed;
      cnt      <= (load || (fire && hit)) ? '0 : fire ? cnt_inc : cnt;
      period   <= (fire && hit) ? cnt_inc : period;
      tick     <= fire;
      wrap     <= fire && hit;
    end
  end
endmodule

// File: tb/tb_lfsr_seg_display.sv
// tb_lfsr_seg_display: directed checks of stepping, load priority, wrap/period, display decode and async reset.
module tb_lfsr_seg_display;
  logic       clk = 1'b0;
  logic       rst_n, en, step, load;
  logic [3:0] seed_in, state, period;
  logic       tick, wrap, a, b, c, d, e, f, g;
  int         tests = 0, fails = 0, wraps;
  logic [3:0] seq [15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011,
                           4'b0101, 4'b1010, 4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [6:0] hex [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                           7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  lfsr_seg_display #(.WIDTH(4), .TAPS(4'b0011), .SEED(4'b0001), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .step(step), .load(load), .seed_in(seed_in),
    .state(state), .tick(tick), .wrap(wrap), .period(period),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; step = 1'b0; load = 1'b0; seed_in = 4'b0000;
    cyc(2);
    chk("rst_state", state, 4'b0001);
    chk("rst_seg", {a, b, c, d, e, f, g}, 7'b1001111);
    chk("rst_tick", tick, 1'b0);
    chk("rst_period", period, 4'b0000);
    rst_n = 1'b1;
    cyc(3);
    chk("pre_tick", tick, 1'b0);
    chk("pre_state", state, 4'b0001);
    cyc();
    chk("first_tick", tick, 1'b1);
    chk("first_state", state, 4'b1000);
    chk("first_seg", {a, b, c, d, e, f, g}, 7'b0000000);
    cyc();
    chk("tick_one_cycle", tick, 1'b0);
    en = 1'b0; load = 1'b1; seed_in = 4'b0001;
    cyc();
    load = 1'b0;
    chk("load_state", state, 4'b0001);
    chk("load_no_tick", tick, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk($sformatf("seq_state%0d", i), state, seq[i]);
      chk($sformatf("seq_seg%0d", i), {a, b, c, d, e, f, g}, hex[seq[i]]);
      chk($sformatf("seq_tick%0d", i), tick, 1'b1);
      chk($sformatf("seq_wrap%0d", i), wrap, i == 14);
      cyc();
      chk($sformatf("idle_tick%0d", i), tick, 1'b0);
    end
    chk("period15", period, 4'd15);
    en = 1'b1;
    cyc(3);
    load = 1'b1; seed_in = 4'b1010;
    cyc();
    load = 1'b0; en = 1'b0;
    chk("load_prio_state", state, 4'b1010);
    chk("load_prio_tick", tick, 1'b0);
    chk("load_prio_seg", {a, b, c, d, e, f, g}, 7'b0001000);
    step = 1'b1; wraps = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      wraps += int'(wrap);
    end
    step = 1'b0;
    chk("held_wrap_last", wrap, 1'b1);
    chk("held_wrap_count", wraps, 1);
    chk("held_period", period, 4'd15);
    chk("held_state", state, 4'b1010);
    load = 1'b1; seed_in = 4'b0001;
    cyc();
    load = 1'b0; en = 1'b1; step = 1'b1;
    cyc(3);
    chk("step_ignored_tick", tick, 1'b0);
    chk("step_ignored_state", state, 4'b0001);
    cyc();
    chk("en_step_tick", tick, 1'b1);
    chk("en_step_state", state, 4'b1000);
    en = 1'b0; step = 1'b0; load = 1'b1; seed_in = 4'b0000;
    cyc();
    load = 1'b0;
    chk("zero_load", state, 4'b0000);
    step = 1'b1;
    cyc();
`ifdef LFSR_SEG_LOCKUP_RECOVER_EN
    chk("recover_state", state, 4'b0001);
    chk("recover_wrap", wrap, 1'b0);
    step = 1'b0;
`else
    chk("lock_state", state, 4'b0000);
    chk("lock_wrap", wrap, 1'b1);
    cyc();
    step = 1'b0;
    chk("lock_state2", state, 4'b0000);
    chk("lock_wrap2", wrap, 1'b1);
    chk("lock_period", period, 4'd1);
`endif
    load = 1'b1; seed_in = 4'b0001;
    cyc();
    load = 1'b0; en = 1'b1;
    cyc(26);
    chk("mid_state", state, 4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", state, 4'b0001);
    chk("async_period", period, 4'd0);
    chk("async_seg", {a, b, c, d, e, f, g}, 7'b1001111);
    cyc();
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_pre_tick", tick, 1'b0);
    cyc();
    chk("post_rst_tick", tick, 1'b1);
    chk("post_rst_state", state, 4'b1000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
